// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 frame scheduler: opcodes, parser states,
// RAM write payload, lane mapping and counter widths.
package ws2812_pkg;

  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned LANE_W   = 2;
  localparam int unsigned SEL_W    = 4;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned GAP_W    = 24;
  localparam int unsigned PERIOD_W = 32;

  // Lane 3 is the first byte of a word (next-ptr), lane 0 the last (B).
  localparam logic [LANE_W-1:0] LANE_FIRST = 2'd3;
  localparam logic [LANE_W-1:0] LANE_LAST  = 2'd0;

  typedef enum logic [BYTE_W-1:0] {
    OP_SET_ADDR = 8'h2A,
    OP_WRITE    = 8'h2C,
    OP_AUTO_ON  = 8'h38,
    OP_AUTO_OFF = 8'h39,
    OP_COMMIT   = 8'h3C
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_WRITE = 2'd2
  } parser_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [SEL_W-1:0]  sel;
    logic [BYTE_W-1:0] data;
  } ram_wr_t;

  function automatic logic [SEL_W-1:0] lane_to_sel(input logic [LANE_W-1:0] lane);
    return SEL_W'(4'b0001 << lane);
  endfunction

endpackage

// File: rtl/frame_gap_timer.sv
// Frame launch timing: saturating inter-frame gap counter, pending request
// flag and the one-cycle frame_rdy pulse.
module frame_gap_timer
  import ws2812_pkg::*;
#(
  parameter logic [GAP_W-1:0] MIN_GAP_CNT = 24'd400_000
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic req_i,
  output logic frame_rdy_o,
  output logic pending_o
);

  localparam int unsigned GAP_XW = GAP_W + 1;

  logic [GAP_W-1:0] gap_q, gap_d;
  logic             pending_q, pending_d;
  logic             rdy_q, rdy_d;
  logic             gap_ok_c, launch_c;

  // gap_q is 0 in the pulse cycle, so launching when gap_q+1 reaches the
  // minimum places the next pulse exactly MIN_GAP_CNT cycles after the last.
  always_comb begin
    gap_ok_c  = ({1'b0, gap_q} + GAP_XW'(1)) >= {1'b0, MIN_GAP_CNT};
    launch_c  = (pending_q | req_i) & gap_ok_c;
    rdy_d     = launch_c;
    pending_d = pending_q | req_i;
    gap_d     = (gap_q >= MIN_GAP_CNT) ? MIN_GAP_CNT : gap_q + GAP_W'(1);
    if (launch_c) begin
      // A fresh request arriving while an older one launches stays queued.
      pending_d = pending_q & req_i;
      gap_d     = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      gap_q     <= MIN_GAP_CNT;
      pending_q <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      gap_q     <= gap_d;
      pending_q <= pending_d;
      rdy_q     <= rdy_d;
    end
  end

  assign frame_rdy_o = rdy_q;
  assign pending_o   = pending_q;

endmodule

// File: rtl/ws2812_frame_sched.sv
// Host byte-stream parser, LED RAM write sequencer and frame scheduler.
// Optional periodic refresh is built when WS2812_AUTO_REFRESH_EN is defined.
module ws2812_frame_sched
  import ws2812_pkg::*;
#(
  parameter logic [GAP_W-1:0]    MIN_GAP_CNT      = 24'd400_000,
  parameter logic [PERIOD_W-1:0] FRAME_PERIOD_CNT = 32'd2_000_000
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              cmd_valid_in,
  input  logic              cmd_dc_in,
  input  logic [BYTE_W-1:0] cmd_byte_in,
  output logic              cmd_ready_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [SEL_W-1:0]  byte_sel_out,
  output logic [BYTE_W-1:0] byte_data_out,
  output logic              layer_en_out,
  output logic              frame_rdy_out
);

  parser_state_e     state_q;
  logic [LANE_W-1:0] lane_q;
  logic [ADDR_W-1:0] addr_q;
  ram_wr_t           wr_q;
  logic              layer_en_q;

  logic pending;
  logic accept_c, is_cmd_c, commit_c, tick_c, req_c;

  assign cmd_ready_out = ~pending;
  assign accept_c      = cmd_valid_in & cmd_ready_out;
  assign is_cmd_c      = accept_c & ~cmd_dc_in;
  assign commit_c      = is_cmd_c & (cmd_byte_in == OP_COMMIT);
  assign req_c         = commit_c | tick_c;

  // Parser FSM with the RAM write port registered alongside it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_IDLE;
      lane_q     <= LANE_FIRST;
      addr_q     <= '0;
      wr_q       <= '0;
      layer_en_q <= 1'b0;
    end else begin
      layer_en_q <= 1'b0;
      if (is_cmd_c) begin
        // Any command abandons a partially written word.
        lane_q <= LANE_FIRST;
        unique case (cmd_byte_in)
          OP_SET_ADDR: state_q <= ST_ADDR;
          OP_WRITE:    state_q <= ST_WRITE;
          default:     state_q <= ST_IDLE;
        endcase
      end else if (accept_c) begin
        unique case (state_q)
          ST_ADDR: begin
            addr_q  <= cmd_byte_in[ADDR_W-1:0];
            lane_q  <= LANE_FIRST;
            state_q <= ST_IDLE;
          end
          ST_WRITE: begin
            layer_en_q <= 1'b1;
            wr_q       <= '{addr: addr_q, sel: lane_to_sel(lane_q), data: cmd_byte_in};
            if (lane_q == LANE_LAST) begin
              lane_q <= LANE_FIRST;
              addr_q <= addr_q + ADDR_W'(1);
            end else begin
              lane_q <= lane_q - LANE_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wr_addr_out   = wr_q.addr;
  assign byte_sel_out  = wr_q.sel;
  assign byte_data_out = wr_q.data;
  assign layer_en_out  = layer_en_q;

`ifdef WS2812_AUTO_REFRESH_EN
  logic                auto_en_q;
  logic [PERIOD_W-1:0] period_q;
  logic                auto_on_c, auto_off_c;

  assign auto_on_c  = is_cmd_c & (cmd_byte_in == OP_AUTO_ON);
  assign auto_off_c = is_cmd_c & (cmd_byte_in == OP_AUTO_OFF);
  assign tick_c     = auto_en_q & (period_q == FRAME_PERIOD_CNT - PERIOD_W'(1));

  // Period counter restarts on enable and on COMMIT so refreshes follow the host.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      auto_en_q <= 1'b0;
      period_q  <= '0;
    end else begin
      if (auto_on_c) begin
        auto_en_q <= 1'b1;
      end else if (auto_off_c) begin
        auto_en_q <= 1'b0;
      end
      if (commit_c || auto_on_c || tick_c) begin
        period_q <= '0;
      end else if (auto_en_q) begin
        period_q <= period_q + PERIOD_W'(1);
      end
    end
  end
`else
  logic unused_period_c;
  assign unused_period_c = ^FRAME_PERIOD_CNT;
  assign tick_c          = 1'b0;
`endif

  frame_gap_timer #(
    .MIN_GAP_CNT(MIN_GAP_CNT)
  ) u_gap (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .req_i       (req_c),
    .frame_rdy_o (frame_rdy_out),
    .pending_o   (pending)
  );

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Randomised self-checking bench for ws2812_frame_sched against a byte-pointer
// and frame-timing reference model.
module tb_ws2812_frame_sched;

  localparam int MIN_GAP = 100;
  localparam int PERIOD  = 1000;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       cmd_valid_in = 1'b0;
  logic       cmd_dc_in = 1'b0;
  logic [7:0] cmd_byte_in = 8'h00;
  logic       cmd_ready_out;
  logic [5:0] wr_addr_out;
  logic [3:0] byte_sel_out;
  logic [7:0] byte_data_out;
  logic       layer_en_out;
  logic       frame_rdy_out;

  ws2812_frame_sched #(
    .MIN_GAP_CNT      (24'(MIN_GAP)),
    .FRAME_PERIOD_CNT (32'(PERIOD))
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .cmd_valid_in  (cmd_valid_in),
    .cmd_dc_in     (cmd_dc_in),
    .cmd_byte_in   (cmd_byte_in),
    .cmd_ready_out (cmd_ready_out),
    .wr_addr_out   (wr_addr_out),
    .byte_sel_out  (byte_sel_out),
    .byte_data_out (byte_data_out),
    .layer_en_out  (layer_en_out),
    .frame_rdy_out (frame_rdy_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: write position is a linear byte pointer over 64 words x 4 lanes.
  typedef struct { int cyc; int addr; int sel; int data; } strobe_t;
  typedef enum { M_IDLE, M_ADDR, M_WRITE } mode_e;

  strobe_t exp_wr[$];
  int      exp_fr[$];
  int      p = 0;
  mode_e   mode = M_IDLE;
  int      last_pulse = -1000000;
  int      pend_from = 0;
  int      pend_to = 0;
  int      last_acc = 0;
  int      fr_seen = 0;

  function automatic void model_reset();
    p = 0;
    mode = M_IDLE;
    last_pulse = -1000000;
    pend_from = 0;
    pend_to = 0;
    exp_wr.delete();
    exp_fr.delete();
  endfunction

  function automatic void model_accept(input logic dc, input logic [7:0] b, input int a);
    last_acc = a;
    if (!dc) begin
      p = (p / 4) * 4;
      mode = (b == 8'h2A) ? M_ADDR : (b == 8'h2C) ? M_WRITE : M_IDLE;
      if (b == 8'h3C) begin
        int t;
        t = (a > last_pulse + MIN_GAP) ? a : last_pulse + MIN_GAP;
        exp_fr.push_back(t);
        last_pulse = t;
        pend_from = a;
        pend_to = t;
      end
    end else if (mode == M_ADDR) begin
      p = int'(b[5:0]) * 4;
      mode = M_IDLE;
    end else if (mode == M_WRITE) begin
      strobe_t s;
      s.cyc = a;
      s.addr = p / 4;
      s.sel = 1 << (3 - (p % 4));
      s.data = int'(b);
      exp_wr.push_back(s);
      p = (p + 1) % 256;
    end
  endfunction

  // Output monitor, sampling 1 time unit after each active edge.
  always @(posedge clk_in) begin
    #1;
    if (rst_n_in) begin
      check_eq("ready", 32'(cmd_ready_out), 32'(!(cyc >= pend_from && cyc < pend_to)));
      if (layer_en_out) begin
        if (exp_wr.size() == 0) begin
          check_eq("strobe_unexpected", 32'(layer_en_out), 32'd0);
        end else begin
          strobe_t s;
          s = exp_wr.pop_front();
          check_eq("strobe_cycle", 32'(cyc), 32'(s.cyc));
          check_eq("strobe_addr", 32'(wr_addr_out), 32'(s.addr));
          check_eq("strobe_sel", 32'(byte_sel_out), 32'(s.sel));
          check_eq("strobe_data", 32'(byte_data_out), 32'(s.data));
        end
      end else if (exp_wr.size() != 0 && exp_wr[0].cyc <= cyc) begin
        check_eq("strobe_missing", 32'(layer_en_out), 32'd1);
        void'(exp_wr.pop_front());
      end
      if (frame_rdy_out) begin
        fr_seen++;
        if (exp_fr.size() == 0) begin
          check_eq("frame_unexpected", 32'(frame_rdy_out), 32'd0);
        end else begin
          check_eq("frame_cycle", 32'(cyc), 32'(exp_fr.pop_front()));
        end
      end else if (exp_fr.size() != 0 && exp_fr[0] <= cyc) begin
        check_eq("frame_missing", 32'(frame_rdy_out), 32'd1);
        void'(exp_fr.pop_front());
      end
    end
  end

  task automatic send(input logic dc, input logic [7:0] b);
    int waitc = 0;
    @(negedge clk_in);
    while (!cmd_ready_out && waitc < 4 * MIN_GAP) begin
      @(negedge clk_in);
      waitc++;
    end
    if (!cmd_ready_out) begin
      check_eq("ready_timeout", 32'(cmd_ready_out), 32'd1);
    end else begin
      cmd_valid_in = 1'b1;
      cmd_dc_in = dc;
      cmd_byte_in = b;
      model_accept(dc, b, cyc + 1);
      @(negedge clk_in);
      cmd_valid_in = 1'b0;
      cmd_byte_in = 8'($urandom);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((exp_wr.size() != 0 || exp_fr.size() != 0) && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    repeat (2) @(negedge clk_in);
    check_eq({tag, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    check_eq({tag, "_fr_left"}, 32'(exp_fr.size()), 32'd0);
  endtask

  initial begin
    int seen0;
    #12;
    check_eq("rst_ready", 32'(cmd_ready_out), 32'd1);
    check_eq("rst_layer_en", 32'(layer_en_out), 32'd0);
    check_eq("rst_frame_rdy", 32'(frame_rdy_out), 32'd0);
    check_eq("rst_sel", 32'(byte_sel_out), 32'd0);
    check_eq("rst_addr", 32'(wr_addr_out), 32'd0);
    check_eq("rst_data", 32'(byte_data_out), 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Word write at address 5, then one byte into word 6.
    send(0, 8'h2A); send(1, 8'h05); send(0, 8'h2C);
    send(1, 8'h11); send(1, 8'h22); send(1, 8'h33); send(1, 8'h44); send(1, 8'h55);
    drain("t1", 20);

    // Address wrap 63 -> 0 -> 1.
    send(0, 8'h2A); send(1, 8'h3F); send(0, 8'h2C);
    for (int i = 0; i < 9; i++) send(1, 8'($urandom));
    drain("t2", 20);

    // Immediate frame, then a deferred one held off by the gap.
    send(0, 8'h3C);
    repeat (8) @(negedge clk_in);
    send(0, 8'h3C);
    send(0, 8'h2C);
    send(1, 8'hA5);
    drain("t3", 4 * MIN_GAP);

    // Unknown opcode ends WRITE mid-word; later data is dropped.
    send(0, 8'h2C); send(1, 8'h01); send(1, 8'h02); send(0, 8'h00); send(1, 8'h03);
    send(0, 8'h2C); send(1, 8'h04);
    drain("t4", 20);

    // Random byte stream.
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [7:0] u;
      r = $urandom_range(0, 99);
      u = 8'($urandom);
      if (u == 8'h2A || u == 8'h2C || u == 8'h3C || u == 8'h38 || u == 8'h39) u = 8'h00;
      if (r < 6)       send(0, 8'h2A);
      else if (r < 12) send(0, 8'h2C);
      else if (r < 15) send(0, 8'h3C);
      else if (r < 18) send(0, u);
      else             send(1, 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk_in);
    end
    drain("rand", 4 * MIN_GAP);

`ifdef WS2812_AUTO_REFRESH_EN
    // Periodic refresh: two pulses, then disabled.
    send(0, 8'h38);
    for (int k = 1; k <= 2; k++) exp_fr.push_back(last_acc + k * PERIOD);
    last_pulse = last_acc + 2 * PERIOD;
    while (cyc < last_acc + 2 * PERIOD + PERIOD / 2) @(negedge clk_in);
    send(0, 8'h39);
    seen0 = fr_seen;
    repeat (PERIOD + PERIOD / 2) @(negedge clk_in);
    check_eq("auto_off_pulses", 32'(fr_seen - seen0), 32'd0);
    drain("t5", 10);
`else
    // Without the refresh build, 0x38 is just an unknown opcode.
    seen0 = fr_seen;
    send(0, 8'h38);
    repeat (PERIOD + PERIOD / 5) @(negedge clk_in);
    check_eq("auto_absent_pulses", 32'(fr_seen - seen0), 32'd0);
    drain("t5", 10);
`endif

    // Reset mid-write with a deferred frame pending.
    send(0, 8'h3C);
    drain("t6a", 4 * MIN_GAP);
    send(0, 8'h2C); send(1, 8'h61); send(1, 8'h62); send(0, 8'h3C);
    repeat (5) @(negedge clk_in);
    check_eq("t6_pending_ready", 32'(cmd_ready_out), 32'd0);
    #2;
    rst_n_in = 1'b0;
    model_reset();
    #1;
    check_eq("t6_rst_layer_en", 32'(layer_en_out), 32'd0);
    check_eq("t6_rst_frame_rdy", 32'(frame_rdy_out), 32'd0);
    check_eq("t6_rst_sel", 32'(byte_sel_out), 32'd0);
    check_eq("t6_rst_addr", 32'(wr_addr_out), 32'd0);
    check_eq("t6_rst_data", 32'(byte_data_out), 32'd0);
    check_eq("t6_rst_ready", 32'(cmd_ready_out), 32'd1);
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    seen0 = fr_seen;
    repeat (2 * MIN_GAP) @(negedge clk_in);
    check_eq("t6_no_frame", 32'(fr_seen - seen0), 32'd0);
    send(0, 8'h2C); send(1, 8'h77);
    drain("t6b", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
